// File: rtl/alu_serial_exec.sv
// Chunk-serial ALU/branch-compare execution unit: CHUNK bits per BUSY cycle,
// carry and equality carried across cycles, valid/ready on both sides.
`ifndef ALU_SEL_W
`define ALU_SEL_W 4
`define ALU_ADD   4'h1
`define ALU_SUB   4'h2
`define ALU_AND   4'h3
`define ALU_OR    4'h4
`define ALU_XOR   4'h5
`define ALU_BNE   4'h6
`define ALU_BLT   4'h7
`define ALU_BGE   4'h8
`define ALU_BLTU  4'h9
`define ALU_BGEU  4'ha
`endif

module alu_serial_exec #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [`ALU_SEL_W-1:0] alu_ctl_i,
  input  logic [XLEN-1:0]       op_a_i,
  input  logic [XLEN-1:0]       op_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  zero_o,
  output logic                  br_taken_o,
  output logic                  illegal_o
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  carry_q, eq_q, in_ready_q, out_valid_q;
  logic                  zero_q, br_q, illegal_q;
  logic [`ALU_SEL_W-1:0] ctl_q;
  logic [XLEN-1:0]       a_q, b_q, res_q;

  // Codes that run through the subtractor (SUB and every branch compare).
  function automatic logic uses_sub(input logic [`ALU_SEL_W-1:0] c);
    case (c)
      `ALU_SUB, `ALU_BNE, `ALU_BLT, `ALU_BGE, `ALU_BLTU, `ALU_BGEU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [CHUNK-1:0] a_c, b_c, bx_c, chunk_res;
  logic [CHUNK:0]   sum_c;
  logic [XLEN-1:0]  res_full;
  logic             eq_d, ovf, lt_s, lt_u, br_d, ill_d;
  int               idx;

  always_comb begin
    idx  = int'(cnt_q) * CHUNK;
    a_c  = a_q[idx +: CHUNK];
    b_c  = b_q[idx +: CHUNK];
    bx_c = uses_sub(ctl_q) ? ~b_c : b_c;
    sum_c = {1'b0, a_c} + {1'b0, bx_c} + {{CHUNK{1'b0}}, carry_q};
    eq_d  = eq_q & (a_c == b_c);
    // Signed overflow from the MSB chunk: operands agree in sign, sum does not.
    ovf  = (a_c[CHUNK-1] == bx_c[CHUNK-1]) & (sum_c[CHUNK-1] != a_c[CHUNK-1]);
    lt_s = sum_c[CHUNK-1] ^ ovf;
    lt_u = ~sum_c[CHUNK];
    chunk_res = '0;
    br_d      = 1'b0;
    ill_d     = 1'b0;
    case (ctl_q)
      `ALU_ADD:  chunk_res = sum_c[CHUNK-1:0];
      `ALU_AND:  chunk_res = a_c & b_c;
      `ALU_OR:   chunk_res = a_c | b_c;
      `ALU_XOR:  chunk_res = a_c ^ b_c;
      `ALU_SUB:  begin chunk_res = sum_c[CHUNK-1:0]; br_d = eq_d;  end
      `ALU_BNE:  begin chunk_res = sum_c[CHUNK-1:0]; br_d = ~eq_d; end
      `ALU_BLT:  begin chunk_res = sum_c[CHUNK-1:0]; br_d = lt_s;  end
      `ALU_BGE:  begin chunk_res = sum_c[CHUNK-1:0]; br_d = ~lt_s; end
      `ALU_BLTU: begin chunk_res = sum_c[CHUNK-1:0]; br_d = lt_u;  end
      `ALU_BGEU: begin chunk_res = sum_c[CHUNK-1:0]; br_d = ~lt_u; end
      default:   ill_d = 1'b1;
    endcase
    res_full = res_q;
    res_full[idx +: CHUNK] = chunk_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      eq_q        <= 1'b0;
      ctl_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      br_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid_i) begin
          state_q    <= S_BUSY;
          in_ready_q <= 1'b0;
          ctl_q      <= alu_ctl_i;
          a_q        <= op_a_i;
          b_q        <= op_b_i;
          cnt_q      <= '0;
          eq_q       <= 1'b1;
          carry_q    <= uses_sub(alu_ctl_i);
        end
        S_BUSY: begin
          res_q   <= res_full;
          carry_q <= sum_c[CHUNK];
          eq_q    <= eq_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            zero_q      <= (res_full == '0);
            br_q        <= br_d;
            illegal_q   <= ill_d;
          end
        end
        S_DONE: if (out_ready_i) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = res_q;
  assign zero_o      = zero_q;
  assign br_taken_o  = br_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed bench for alu_serial_exec: hand-computed vectors checked with
// immediate assertions, plus backpressure, async reset and flush scenarios.
`ifndef ALU_SEL_W
`define ALU_SEL_W 4
`define ALU_ADD   4'h1
`define ALU_SUB   4'h2
`define ALU_AND   4'h3
`define ALU_OR    4'h4
`define ALU_XOR   4'h5
`define ALU_BNE   4'h6
`define ALU_BLT   4'h7
`define ALU_BGE   4'h8
`define ALU_BLTU  4'h9
`define ALU_BGEU  4'ha
`endif

module tb_alu_serial_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, br_taken, illegal;
  logic [`ALU_SEL_W-1:0] alu_ctl = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_serial_exec #(.XLEN(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .alu_ctl_i(alu_ctl), .op_a_i(op_a), .op_b_i(op_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .zero_o(zero), .br_taken_o(br_taken), .illegal_o(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for out_valid, check latency and outputs, complete handshake.
  task automatic run_op(input string tag, input logic [`ALU_SEL_W-1:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_res, input logic e_zero,
                        input logic e_br, input logic e_ill);
    int n;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_ctl = c; op_a = a; op_b = b;
    step();
    in_valid = 1'b0; alu_ctl = '0; op_a = '0; op_b = '0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({tag, ".latency"}, 32'(n), 32'd4);
    chk({tag, ".result"}, result, e_res);
    chk({tag, ".flags"}, {29'd0, zero, br_taken, illegal}, {29'd0, e_zero, e_br, e_ill});
    step();
    chk({tag, ".drop"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int n;
    logic seen;
    #12;
    chk("reset.out", {28'd0, out_valid, zero, br_taken, illegal}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();
    chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    run_op("add_carry", `ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1, 0, 0);
    run_op("add", `ALU_ADD, 32'd7, 32'd5, 32'd12, 0, 0, 0);
    run_op("beq", `ALU_SUB, 32'h1234_5678, 32'h1234_5678, 32'h0, 1, 1, 0);
    run_op("sub", `ALU_SUB, 32'd100, 32'd1, 32'd99, 0, 0, 0);
    run_op("bne", `ALU_BNE, 32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 0, 1, 0);
    run_op("blt", `ALU_BLT, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 1, 0);
    run_op("bltu", `ALU_BLTU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("bge_ovf", `ALU_BGE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 0, 0, 0);
    run_op("bgeu", `ALU_BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 0, 1, 0);
    run_op("or", `ALU_OR, 32'h0000_F0F0, 32'h1234_0000, 32'h1234_F0F0, 0, 0, 0);
    run_op("illegal", 4'h0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1, 0, 1);

    // XOR with in_valid held high and operands changing during BUSY.
    in_valid = 1'b1; alu_ctl = `ALU_XOR; op_a = 32'hF0F0_F0F0; op_b = 32'hFFFF_0000;
    step();
    n = 0;
    while (!out_valid && n < 20) begin
      chk("xor.busy_in_ready", 32'(in_ready), 32'd0);
      alu_ctl = `ALU_ADD; op_a = $urandom; op_b = $urandom;
      step(); n++;
    end
    in_valid = 1'b0;
    chk("xor.latency", 32'(n), 32'd4);
    chk("xor.result", result, 32'h0F0F_F0F0);
    step();
    chk("xor.drop", {30'd0, out_valid, in_ready}, 32'b01);

    // Backpressure: outputs held for 10 cycles while out_ready=0.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctl = `ALU_AND; op_a = 32'hFF00_FF00; op_b = 32'h0FF0_0FF0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("bp.latency", 32'(n), 32'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp.hold", {out_valid, in_ready, zero, result[28:0]},
          {1'b1, 1'b0, 1'b0, 29'h0F00_0F00});
      step();
    end
    in_valid = 1'b0;
    chk("bp.result", result, 32'h0F00_0F00);
    out_ready = 1'b1;
    step();
    chk("bp.release", {30'd0, out_valid, in_ready}, 32'b01);

    // Asynchronous reset in the middle of BUSY (counter=2).
    in_valid = 1'b1; alu_ctl = `ALU_ADD; op_a = 32'h1111_1111; op_b = 32'h1111_1111;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("rst_mid.partial", 32'(result[15:0]), 32'h2222);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.result", result, 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    n = 0;
    seen = 1'b0;
    while (n < 8) begin seen |= out_valid; step(); n++; end
    chk("rst_mid.no_valid", 32'(seen), 32'd0);

    // Flush during BUSY: back to IDLE, never valid.
    in_valid = 1'b1; alu_ctl = `ALU_ADD; op_a = 32'd3; op_b = 32'd4;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    seen = out_valid;
    for (int i = 0; i < 8; i++) begin step(); seen |= out_valid; end
    chk("flush.no_valid", 32'(seen), 32'd0);

    run_op("after_flush", `ALU_ADD, 32'd3, 32'd4, 32'd7, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
